// File: rtl/led_animator.sv
// led_animator: prescaled frame counter plus pattern generator (RUN, BOUNCE,
// FILL, COUNT) with direction reversal, pause and single-step.
module led_animator #(
    parameter int unsigned LED_W = 16,
    parameter int unsigned CNT_W = 27,
    parameter int unsigned DIV0  = 100_000_000,
    parameter int unsigned DIV1  = 50_000_000,
    parameter int unsigned DIV2  = 25_000_000,
    parameter int unsigned DIV3  = 12_500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    input  logic             dir,
    input  logic             pause,
    input  logic             step,
    output logic [LED_W-1:0] led,
    output logic [LED_W-1:0] frame_no,
    output logic             frame_tick
);

    localparam logic [1:0] M_RUN    = 2'd0;
    localparam logic [1:0] M_BOUNCE = 2'd1;
    localparam logic [1:0] M_FILL   = 2'd2;

    localparam logic [LED_W-1:0] ONE = LED_W'(1);

    logic [1:0]       mode_q;
    logic [1:0]       speed_q;
    logic [CNT_W-1:0] cnt;

    logic             change_c;
    logic [CNT_W-1:0] div_last_c;
    logic [LED_W-1:0] frame_last_c;
    logic [LED_W-1:0] frame_next_c;
    logic [LED_W-1:0] bounce_pos_c;
    logic [LED_W-1:0] raw_c;
    logic [LED_W-1:0] rev_c;
    logic [LED_W-1:0] led_next_c;

    // A new mode or speed restarts the animation from frame 0
    assign change_c = (mode != mode_q) || (speed != speed_q);

    // Terminal prescaler count for the registered speed
    always_comb begin
        div_last_c = CNT_W'(DIV0 - 1);
        case (speed_q)
            2'd0:    div_last_c = CNT_W'(DIV0 - 1);
            2'd1:    div_last_c = CNT_W'(DIV1 - 1);
            2'd2:    div_last_c = CNT_W'(DIV2 - 1);
            default: div_last_c = CNT_W'(DIV3 - 1);
        endcase
    end

    // Last frame of the current mode and the wrapped successor frame
    always_comb begin
        frame_last_c = '1;
        case (mode_q)
            M_RUN:    frame_last_c = LED_W'(LED_W - 1);
            M_BOUNCE: frame_last_c = LED_W'(2 * LED_W - 3);
            M_FILL:   frame_last_c = LED_W'(LED_W);
            default:  frame_last_c = '1;
        endcase
        frame_next_c = (frame_no == frame_last_c) ? '0 : frame_no + ONE;
    end

    // Pattern for the current frame, optionally bit-reversed
    always_comb begin
        bounce_pos_c = (frame_no < LED_W'(LED_W)) ? frame_no
                                                  : LED_W'(2 * LED_W - 2) - frame_no;
        raw_c = frame_no;
        case (mode_q)
            M_RUN:    raw_c = ONE << frame_no;
            M_BOUNCE: raw_c = ONE << bounce_pos_c;
            M_FILL:   raw_c = (ONE << frame_no) - ONE;
            default:  raw_c = frame_no;
        endcase
        rev_c = '0;
        for (int i = 0; i < LED_W; i++) begin
            rev_c[i] = raw_c[LED_W-1-i];
        end
        led_next_c = dir ? rev_c : raw_c;
    end

    // Prescaler, frame counter and LED register; rst > change > pause/step > tick
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            frame_no   <= '0;
            led        <= '0;
            frame_tick <= 1'b0;
            mode_q     <= mode;
            speed_q    <= speed;
        end else begin
            led <= led_next_c;
            if (change_c) begin
                mode_q     <= mode;
                speed_q    <= speed;
                cnt        <= '0;
                frame_no   <= '0;
                frame_tick <= 1'b0;
            end else if (pause) begin
                frame_tick <= step;
                if (step) begin
                    frame_no <= frame_next_c;
                end
            end else if (cnt == div_last_c) begin
                cnt        <= '0;
                frame_no   <= frame_next_c;
                frame_tick <= 1'b1;
            end else begin
                cnt        <= cnt + CNT_W'(1);
                frame_tick <= 1'b0;
            end
        end
    end

endmodule
